output_error_unit: RTL

- Sits directly downstream of training_label in the 2-layer ANN training path.
- Takes the one-hot target vector plus the output-layer activations, streamed one per cycle.
- Emits the per-neuron error (activation - target) as a stream for the backprop stage.
- Computes argmax prediction and correctness, and keeps running sample and correct-prediction counters.

---
 rtl/output_error_unit_if.sv | 27 ++
 rtl/output_error_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/output_error_unit_if.sv
// Stream bundle between the output layer, the error unit and the backprop stage.
//   act_*  : activations into the error unit (valid/ready, signed data)
//   err_*  : per-neuron error words out of the error unit (valid/ready, data, index, last)
// slave  = error unit view, master = producer/consumer (environment) view.
interface output_error_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_W      = 4
);
    logic                         act_valid;
    logic signed [DATA_WIDTH-1:0] act_data;
    logic                         act_ready;
    logic                         err_valid;
    logic signed [DATA_WIDTH-1:0] err_data;
    logic [IDX_W-1:0]             err_idx;
    logic                         err_last;
    logic                         err_ready;

    modport slave (
        input  act_valid, act_data, err_ready,
        output act_ready, err_valid, err_data, err_idx, err_last
    );

    modport master (
        output act_valid, act_data, err_ready,
        input  act_ready, err_valid, err_data, err_idx, err_last
    );
endinterface

// File: rtl/output_error_unit.sv
// Output-layer error unit: streams err = sat(act - target) per neuron, tracks the
// argmax prediction per sample and keeps saturating sample / correct counters.
// Ports:
//   clk, rst_vals      clock, synchronous active-high reset
//   label_in, start    one-hot target, latched when a sample starts in IDLE
//   clear_counts       synchronous clear of both statistics counters
//   bus (slave)        act_* in, err_* out (see output_error_unit_if)
//   pred_*             per-sample prediction pulse, class and correctness
//   sample_count, correct_count, busy
module output_error_unit #(
    parameter int unsigned layers     = 3,
    parameter int          rows [layers] = '{50, 30, 10},
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned N         = rows[layers-1],
    localparam int unsigned IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_vals,
    input  logic [N-1:0]         label_in,
    input  logic                 start,
    input  logic                 clear_counts,
    output_error_unit_if.slave   bus,
    output logic                 pred_valid,
    output logic [IDX_W-1:0]     pred_class,
    output logic                 pred_correct,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] correct_count,
    output logic                 busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                       state, state_nxt;
    logic [N-1:0]                 label_q;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             max_idx;
    logic signed [DATA_WIDTH-1:0] max_val;

    logic                         accept;
    logic                         last_acc;
    logic                         new_max;
    logic [IDX_W-1:0]             final_idx;
    logic [DATA_WIDTH:0]          target;
    logic [DATA_WIDTH:0]          diff;
    logic [DATA_WIDTH-1:0]        err_sat;

    // State register
    always_ff @(posedge clk) begin
        if (rst_vals) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (last_acc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; act_ready follows err_ready for full throughput
    always_comb begin
        bus.act_ready = 1'b0;
        busy          = 1'b0;
        case (state)
            STREAM: begin
                bus.act_ready = !bus.err_valid || bus.err_ready;
                busy          = 1'b1;
            end
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    // Error arithmetic at DATA_WIDTH+1 bits with saturation, plus argmax decisions
    always_comb begin
        accept    = bus.act_valid && bus.act_ready;
        last_acc  = accept && (idx == LAST_IDX);
        // Strict compare keeps the lowest index on ties
        new_max   = (idx == '0) || (bus.act_data > max_val);
        final_idx = new_max ? idx : max_idx;
        target    = label_q[idx] ? (DATA_WIDTH+1)'(1 << FRAC_BITS) : '0;
        diff      = {bus.act_data[DATA_WIDTH-1], bus.act_data} - target;
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
            err_sat = {diff[DATA_WIDTH], {(DATA_WIDTH-1){~diff[DATA_WIDTH]}}};
        else
            err_sat = diff[DATA_WIDTH-1:0];
    end

    // Datapath: label latch, error output register, argmax, prediction, counters
    always_ff @(posedge clk) begin
        if (rst_vals) begin
            label_q       <= '0;
            idx           <= '0;
            max_idx       <= '0;
            max_val       <= '0;
            bus.err_valid <= 1'b0;
            bus.err_data  <= '0;
            bus.err_idx   <= '0;
            bus.err_last  <= 1'b0;
            pred_valid    <= 1'b0;
            pred_class    <= '0;
            pred_correct  <= 1'b0;
            sample_count  <= '0;
            correct_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                label_q <= label_in;
                idx     <= '0;
            end

            if (accept) begin
                bus.err_valid <= 1'b1;
                bus.err_data  <= err_sat;
                bus.err_idx   <= idx;
                bus.err_last  <= (idx == LAST_IDX);
                if (new_max) begin
                    max_val <= bus.act_data;
                    max_idx <= idx;
                end
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end else if (bus.err_ready) begin
                bus.err_valid <= 1'b0;
            end

            // Loaded on the last accept so the pulse lands in the DONE cycle
            pred_valid <= last_acc;
            if (last_acc) begin
                pred_class   <= final_idx;
                pred_correct <= label_q[final_idx];
            end

            // Clear beats the DONE-cycle increment
            if (clear_counts) begin
                sample_count  <= '0;
                correct_count <= '0;
            end else if (state == DONE) begin
                if (sample_count != '1)
                    sample_count <= sample_count + CNT_WIDTH'(1);
                if (pred_correct && (correct_count != '1))
                    correct_count <= correct_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
